multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It sits directly upstream of alu_control.
- Decodes opcode[5:0] from the instruction register and sequences fetch, decode, execute, memory and writeback steps.
- Drives aluop[1:0] to alu_control, plus every datapath mux select and write enable.
- Supports memory wait states through a mem_ready handshake, with a bounded timeout.

Parameters:
- TIMEOUT_CYCLES, 255, max consecutive cycles waiting on mem_ready before abort; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from IR.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register writeback select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  2  to alu_control: 00 = add, 01 = sub, 10 = funct-decoded.
- illegal_op  out  1  one-cycle pulse when an unknown opcode is decoded.
- mem_timeout  out  1  one-cycle pulse when a wait is aborted.
- state_dbg  out  4  current state encoding.

Behaviour:
- State register resets asynchronously to FETCH (0). Wait counter resets to 0.
- While rst_n=0: all write enables, mem_read, mem_write, illegal_op and mem_timeout are 0; other outputs take their FETCH values.
- Outputs are Moore, decoded from state. The write enables in memory states are additionally gated by mem_ready.
- Unlisted outputs are 0 in each state below.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- FETCH(0): mem_read=1, alu_src_b=01, aluop=00. ir_write and pc_write = mem_ready. mem_ready=1 -> DECODE; otherwise stay.
- DECODE(1): alu_src_b=11, aluop=00 (branch target precompute). Next state by opcode:
  - LW/SW -> MEM_ADDR(2).
  - R -> EXECUTE(6).
  - BEQ -> BRANCH(8).
  - J -> JUMP(9).
  - ADDI -> ADDI_EXEC(10).
  - Other -> FETCH, with illegal_op=1 for that cycle.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, aluop=00. LW -> MEM_READ(3); SW -> MEM_WRITE(5).
- MEM_READ(3): mem_read=1, i_or_d=1. Wait for mem_ready, then -> MEM_WB(4).
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE(5): mem_write=1, i_or_d=1. mem_ready -> FETCH.
- EXECUTE(6): alu_src_a=1, alu_src_b=00, aluop=10 -> R_COMPLETE(7).
- R_COMPLETE(7): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP(9): pc_write=1, pc_source=10 -> FETCH.
- ADDI_EXEC(10): alu_src_a=1, alu_src_b=10, aluop=00 -> ADDI_WB(11).
- ADDI_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Encodings 12-15 are unreachable; if entered, go to FETCH next cycle with all enables 0.
- Wait counter:
  - Clears on entry to any wait state (FETCH, MEM_READ, MEM_WRITE) and whenever mem_ready=1.
  - Increments each cycle waiting with mem_ready=0, saturating at all-ones.
  - When count == TIMEOUT_CYCLES-1 with mem_ready still 0 (TIMEOUT_CYCLES≠0): mem_timeout pulses, FSM goes to FETCH, and no write enable fires.
  - A timeout in FETCH restarts the fetch.
- mem_ready in the same cycle as timeout expiry: mem_ready wins; normal transition, no pulse.
- Reset mid-instruction: immediate return to FETCH; a partially completed instruction leaves no writes.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings (4-bit localparams);
  - opcode constants;
  - ALUOP_ADD/SUB/FUNCT constants, also to be used by alu_control;
  - alu_src_b and pc_source select encodings.
- One natural sub-module: mem_wait_timer (counter, clear, expiry compare).

Test Plan:
- Reset: hold rst_n=0 across a clk edge, release -> state_dbg=0, all enables 0 during reset, mem_read=1 after release.
- R-type, mem_ready=1: opcode=000000 -> states 0,1,6,7,0. aluop=10 in state 6; reg_write=1, reg_dst=1 in state 7; 4 cycles total.
- LW with 3 wait cycles on the data read: opcode=100011, mem_ready low 3 cycles in state 3 -> stays in 3 for 4 cycles, then state 4 with reg_write=1, mem_to_reg=1. No early write.
- BEQ then J: state 8 shows aluop=01, pc_write_cond=1, pc_source=01; state 9 shows pc_write=1, pc_source=10.
- Illegal opcode 111111 -> state 1 then 0, illegal_op=1 for exactly one cycle, reg_write/mem_write never asserted.
- Timeout with TIMEOUT_CYCLES=4: SW with mem_ready held 0 -> mem_timeout pulses after 4 cycles in state 5, mem_write gated, next state 0. Repeat with mem_ready=1 on expiry cycle -> no pulse.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU operation classes and datapath mux selects (also used by alu_control).
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH      = 4'd0,
      ST_DECODE     = 4'd1,
      ST_MEM_ADDR   = 4'd2,
      ST_MEM_READ   = 4'd3,
      ST_MEM_WB     = 4'd4,
      ST_MEM_WRITE  = 4'd5,
      ST_EXECUTE    = 4'd6,
      ST_R_COMPLETE = 4'd7,
      ST_BRANCH     = 4'd8,
      ST_JUMP       = 4'd9,
      ST_ADDI_EXEC  = 4'd10,
      ST_ADDI_WB    = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUB_REG     = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SHL = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold a memory access open until mem_ready.
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready and flags the cycle on
// which the wait must be abandoned.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic mem_ready,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Held at zero outside wait states, so every entry into a wait starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!waiting || mem_ready || expired) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && waiting && !mem_ready && (count == LAST);

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// and drives every mux select, write enable and the aluop class for alu_control.
//
//  state            | meaning
//  -----------------+-----------------------------------------------
//  FETCH (0)        | read instruction at PC, PC+4, load IR on mem_ready
//  DECODE (1)       | register read, branch target into ALUOut
//  MEM_ADDR (2)     | A + sign-extended offset for LW/SW
//  MEM_READ (3)     | data read, wait for mem_ready
//  MEM_WB (4)       | MDR into rt
//  MEM_WRITE (5)    | data write, wait for mem_ready
//  EXECUTE (6)      | R-type ALU operation
//  R_COMPLETE (7)   | ALUOut into rd
//  BRANCH (8)       | compare A/B, PC <= ALUOut on zero
//  JUMP (9)         | PC <= jump target
//  ADDI_EXEC (10)   | A + sign-extended immediate
//  ADDI_WB (11)     | ALUOut into rt
module multicycle_main_control
   import mips_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [1:0] aluop,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state_dbg
);

   state_t state;
   state_t state_next;
   logic   in_wait;
   logic   timeout_now;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
      end else begin
         state <= state_next;
      end
   end

   assign in_wait   = is_wait_state(state);
   assign state_dbg = state;

   mem_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_mem_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .waiting   (in_wait),
      .mem_ready (mem_ready),
      .expired   (timeout_now)
   );

   always_comb begin
      state_next    = ST_FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALUB_REG;
      pc_source     = PCSRC_ALU;
      aluop         = ALUOP_ADD;
      illegal_op    = 1'b0;
      mem_timeout   = timeout_now;

      case (state)
         ST_FETCH: begin
            mem_read   = 1'b1;
            alu_src_b  = ALUB_FOUR;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            state_next = mem_ready ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            alu_src_b = ALUB_IMM_SHL;
            case (opcode)
               OP_LW, OP_SW: state_next = ST_MEM_ADDR;
               OP_R:         state_next = ST_EXECUTE;
               OP_BEQ:       state_next = ST_BRANCH;
               OP_J:         state_next = ST_JUMP;
               OP_ADDI:      state_next = ST_ADDI_EXEC;
               default: begin
                  illegal_op = 1'b1;
                  state_next = ST_FETCH;
               end
            endcase
         end
         ST_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
            if (opcode == OP_LW) begin
               state_next = ST_MEM_READ;
            end else if (opcode == OP_SW) begin
               state_next = ST_MEM_WRITE;
            end
         end
         ST_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) begin
               state_next = ST_MEM_WB;
            end else if (!timeout_now) begin
               state_next = ST_MEM_READ;
            end
         end
         ST_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_MEM_WRITE: begin
            // The store strobe is withdrawn on the cycle the wait is abandoned.
            mem_write = !timeout_now;
            i_or_d    = 1'b1;
            if (!mem_ready && !timeout_now) begin
               state_next = ST_MEM_WRITE;
            end
         end
         ST_EXECUTE: begin
            alu_src_a  = 1'b1;
            aluop      = ALUOP_FUNCT;
            state_next = ST_R_COMPLETE;
         end
         ST_R_COMPLETE: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a     = 1'b1;
            aluop         = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         ST_ADDI_EXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = ALUB_IMM;
            state_next = ST_ADDI_WB;
         end
         ST_ADDI_WB: begin
            reg_write = 1'b1;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase

      // Reset is asynchronous: suppress every strobe while it is held.
      if (!rst_n) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         illegal_op    = 1'b0;
         mem_timeout   = 1'b0;
      end
   end

endmodule
